// File: rtl/div_scheduler_if.sv
// Bundle of lane request/response and divider handshake signals for div_scheduler.
// The scheduler connects through the slave modport; lanes plus divider sit on master.
`timescale 1ns/1ps

interface div_scheduler_if #(
    parameter int N = 4,
    parameter int W = 6
);
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N*W-1:0] y_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_z;
    logic           rsp_err;
    logic           div_start;
    logic [W-1:0]   div_x;
    logic [W-1:0]   div_y;
    logic           div_done;
    logic [W-1:0]   div_z;

    modport slave (
        input  req, x_in, y_in, div_done, div_z,
        output gnt, rsp_valid, rsp_z, rsp_err, div_start, div_x, div_y
    );

    modport master (
        output req, x_in, y_in, div_done, div_z,
        input  gnt, rsp_valid, rsp_z, rsp_err, div_start, div_x, div_y
    );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one iterative divider among N lanes.
// Divide-by-zero is answered locally; a stuck divider is abandoned after TMO wait cycles.
`timescale 1ns/1ps

module div_scheduler #(
    parameter int N   = 4,
    parameter int W   = 6,
    parameter int TMO = 63
) (
    input logic            c,
    input logic            rst,
    div_scheduler_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel_idx;
    logic [IW:0]   cand;
    logic          sel_found;
    logic [W-1:0]  div_x_q;
    logic [W-1:0]  div_y_q;
    logic [W-1:0]  rsp_z_q;
    logic          rsp_err_q;
    logic [7:0]    cnt;
    logic          cnt_hit;
    logic          y_zero;
    logic          div_start_c;
    logic [N-1:0]  rsp_valid_c;

    // The counter holds the number of completed WAIT cycles, so this cycle is the TMO-th when cnt+1 == TMO.
    assign cnt_hit = (({1'b0, cnt} + 9'd1) == 9'(TMO));
    assign y_zero  = (div_y_q == '0);

    // Pick the first requesting lane at or above rr_ptr, wrapping around modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!sel_found && bus.req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the single-cycle divider start and response pulses.
    always_comb begin
        state_nxt   = state;
        div_start_c = 1'b0;
        rsp_valid_c = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (y_zero) begin
                    state_nxt = RESP;
                end else begin
                    div_start_c = 1'b1;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (bus.div_done || cnt_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = gnt_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, operand latch, wait counter, result capture and round-robin pointer advance.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            gnt_q     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            div_x_q   <= '0;
            div_y_q   <= '0;
            rsp_z_q   <= '0;
            rsp_err_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt_q   <= N'(1) << sel_idx;
                        gnt_idx <= sel_idx;
                        div_x_q <= bus.x_in[sel_idx*W +: W];
                        div_y_q <= bus.y_in[sel_idx*W +: W];
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (y_zero) begin
                        rsp_z_q   <= '1;
                        rsp_err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus.div_done) begin
                        rsp_z_q   <= bus.div_z;
                        rsp_err_q <= 1'b0;
                    end else if (cnt_hit) begin
                        rsp_z_q   <= '1;
                        rsp_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    gnt_q  <= '0;
                    rr_ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.div_start = div_start_c;
    assign bus.div_x     = div_x_q;
    assign bus.div_y     = div_y_q;
endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: directed vector table, hand-written corner
// sequences and a randomized multi-lane run checked against a transaction-level model.
`timescale 1ns/1ps

module tb_div_scheduler;
    localparam int N   = 4;
    localparam int W   = 6;
    localparam int TMO = 63;

    typedef struct {
        int lane;
        int x;
        int y;
        int lat;
        int zov;
        int exp_z;
        int exp_err;
        int exp_cyc;
    } vec_t;

    logic c = 1'b0;
    logic rst;

    div_scheduler_if #(.N(N), .W(W)) bus ();

    div_scheduler #(.N(N), .W(W), .TMO(TMO)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period.
    always #5 c = ~c;

    int n_checks = 0;
    int n_fail   = 0;

    // Divider model: answers div_lat cycles after a start (0 = never answers).
    int         div_lat = 1;
    int         zov     = -1;
    bit         busy    = 1'b0;
    int         dcnt    = 0;
    int         cur_lat = 0;
    logic [5:0] op_x    = '0;
    logic [5:0] op_y    = '0;
    bit         spur    = 1'b0;
    logic [5:0] spur_z  = '0;

    vec_t vecs[8];
    int   rx[N];
    int   ry[N];
    int   rq[N];
    int   lx[N];
    int   ly[N];
    logic [N-1:0] lane_req;
    int   k;
    int   saw3;
    int   model_ptr;
    int   cl;
    int   cand_lane;
    int   cyc;
    int   exp_cyc;
    int   exp_z;
    int   exp_err;
    int   n_ops;
    logic [N-1:0] exp_gnt;
    bit   idle;
    bit   pending;
    bit   active;
    bit   post_resp;
    bit   resp_now;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task divider_step();
        bus.div_done = 1'b0;
        if (spur) begin
            bus.div_done = 1'b1;
            bus.div_z    = spur_z;
            spur         = 1'b0;
        end else begin
            if (busy) begin
                dcnt++;
                if (dcnt == cur_lat) begin
                    bus.div_done = 1'b1;
                    bus.div_z    = (zov >= 0) ? 6'(zov) : ((op_y == 0) ? 6'h3F : op_x / op_y);
                    busy         = 1'b0;
                end
            end
            if (bus.div_start === 1'b1) begin
                busy    = (div_lat > 0);
                dcnt    = 0;
                cur_lat = div_lat;
                op_x    = bus.div_x;
                op_y    = bus.div_y;
            end
        end
    endtask

    task tick();
        @(negedge c);
        divider_step();
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int j = 0; j < N; j++) begin
            if (r[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    // One isolated single-lane operation from the vector table.
    task automatic apply_stimulus(input vec_t v);
        logic [N-1:0] oh;
        int lat_cnt;
        int starts;
        bit seen;
        oh      = N'(1) << v.lane;
        div_lat = v.lat;
        zov     = v.zov;
        bus.x_in[v.lane*W +: W] = 6'(v.x);
        bus.y_in[v.lane*W +: W] = 6'(v.y);
        bus.req = oh;
        tick();
        check_output("vec_gnt", bus.gnt, oh);
        check_output("vec_div_x", bus.div_x, v.x);
        check_output("vec_div_y", bus.div_y, v.y);
        check_output("vec_div_start", bus.div_start, (v.y != 0));
        lat_cnt = 0;
        starts  = 0;
        seen    = 1'b0;
        while (!seen && lat_cnt < 300) begin
            tick();
            lat_cnt++;
            if (bus.div_start) starts++;
            if (bus.rsp_valid != 0) seen = 1'b1;
        end
        check_output("vec_rsp_seen", seen, 1);
        check_output("vec_latency", lat_cnt, v.exp_cyc);
        check_output("vec_rsp_valid", bus.rsp_valid, oh);
        check_output("vec_rsp_z", bus.rsp_z, v.exp_z);
        check_output("vec_rsp_err", bus.rsp_err, v.exp_err);
        check_output("vec_extra_start", starts, 0);
        bus.req = '0;
        tick();
        check_output("vec_rsp_pulse", bus.rsp_valid, 0);
        check_output("vec_gnt_release", bus.gnt, 0);
        zov = -1;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vecs[0] = '{2, 36,  6,  4, -1,  6, 0,  5};
        vecs[1] = '{1, 10,  0,  3, -1, 63, 1,  1};
        vecs[2] = '{0, 63,  7,  1, -1,  9, 0,  2};
        vecs[3] = '{3,  5,  9,  2, -1,  0, 0,  3};
        vecs[4] = '{3, 63,  1,  8, -1, 63, 0,  9};
        vecs[5] = '{0, 50,  4,  0, -1, 63, 1, 64};
        vecs[6] = '{1, 20,  3, 63,  5,  5, 0, 64};
        vecs[7] = '{2, 40, 13, 62, -1,  3, 0, 63};
        rx = '{60, 45, 33, 63};
        ry = '{5, 9, 4, 2};
        rq = '{12, 5, 8, 31};

        rst          = 1'b1;
        bus.req      = '0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.div_done = 1'b0;
        bus.div_z    = '0;
        tick();
        tick();
        check_output("rst_gnt", bus.gnt, 0);
        check_output("rst_rsp_valid", bus.rsp_valid, 0);
        check_output("rst_rsp_z", bus.rsp_z, 0);
        check_output("rst_rsp_err", bus.rsp_err, 0);
        check_output("rst_div_start", bus.div_start, 0);
        check_output("rst_div_x", bus.div_x, 0);
        check_output("rst_div_y", bus.div_y, 0);
        rst = 1'b0;

        // Round robin: every lane requests continuously.
        for (int i = 0; i < N; i++) begin
            bus.x_in[i*W +: W] = 6'(rx[i]);
            bus.y_in[i*W +: W] = 6'(ry[i]);
        end
        div_lat = 3;
        bus.req = '1;
        for (int g = 0; g < 5; g++) begin
            k = 0;
            tick();
            while (bus.gnt == 0 && k < 20) begin
                tick();
                k++;
            end
            check_output("rr_gnt", bus.gnt, 1 << (g % N));
            k = 0;
            while (bus.rsp_valid == 0 && k < 100) begin
                tick();
                k++;
            end
            check_output("rr_rsp_valid", bus.rsp_valid, 1 << (g % N));
            check_output("rr_rsp_z", bus.rsp_z, rq[g % N]);
            check_output("rr_rsp_err", bus.rsp_err, 0);
            if (g == 4) bus.req = '0;
            tick();
        end

        // Directed single-lane vectors including divide-by-zero, timeout and coincident done.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Spurious div_done while idle must not disturb anything.
        spur_z = 6'd17;
        spur   = 1'b1;
        tick();
        tick();
        check_output("spur_gnt", bus.gnt, 0);
        check_output("spur_rsp_valid", bus.rsp_valid, 0);
        check_output("spur_rsp_z", bus.rsp_z, 3);
        check_output("spur_rsp_err", bus.rsp_err, 0);
        check_output("spur_div_start", bus.div_start, 0);

        // Asynchronous reset in the middle of a WAIT.
        bus.x_in[3*W +: W] = 6'd30;
        bus.y_in[3*W +: W] = 6'd5;
        div_lat = 0;
        bus.req = 4'b1000;
        tick();
        check_output("rstw_pre_gnt", bus.gnt, 4'b1000);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_output("rstw_gnt", bus.gnt, 0);
        check_output("rstw_rsp_valid", bus.rsp_valid, 0);
        check_output("rstw_div_start", bus.div_start, 0);
        check_output("rstw_div_x", bus.div_x, 0);
        check_output("rstw_div_y", bus.div_y, 0);
        check_output("rstw_rsp_z", bus.rsp_z, 0);
        check_output("rstw_rsp_err", bus.rsp_err, 0);
        busy = 1'b0;
        bus.x_in[0 +: W] = 6'd12;
        bus.y_in[0 +: W] = 6'd4;
        bus.req = 4'b1001;
        div_lat = 2;
        @(negedge c);
        #2 rst = 1'b0;
        saw3 = 0;
        k = 0;
        tick();
        while (bus.gnt == 0 && k < 10) begin
            tick();
            k++;
        end
        check_output("rstw_first_gnt", bus.gnt, 4'b0001);
        k = 0;
        while (bus.rsp_valid == 0 && k < 100) begin
            tick();
            k++;
            if (bus.rsp_valid[3]) saw3 = 1;
        end
        check_output("rstw_rsp_valid", bus.rsp_valid, 4'b0001);
        check_output("rstw_rsp_z_after", bus.rsp_z, 3);
        check_output("rstw_lost_rsp", saw3, 0);
        bus.req = '0;
        tick();
        tick();

        // Randomized multi-lane traffic against a transaction-level model.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        busy      = 1'b0;
        lane_req  = '0;
        model_ptr = 0;
        idle      = 1'b1;
        pending   = 1'b0;
        active    = 1'b0;
        post_resp = 1'b0;
        cl        = 0;
        n_ops     = 0;
        exp_gnt   = '0;
        div_lat   = $urandom_range(1, 12);
        for (int i = 0; i < N; i++) begin
            lx[i] = 0;
            ly[i] = 1;
        end
        for (int it = 0; it < 3000; it++) begin
            tick();
            resp_now = 1'b0;
            if (pending) begin
                pending = 1'b0;
                check_output("rnd_gnt", bus.gnt, exp_gnt);
                if (exp_gnt == 0) begin
                    idle = 1'b1;
                end else begin
                    active = 1'b1;
                    cyc    = 0;
                    check_output("rnd_div_x", bus.div_x, lx[cl]);
                    check_output("rnd_div_y", bus.div_y, ly[cl]);
                    check_output("rnd_div_start", bus.div_start, (ly[cl] != 0));
                    exp_cyc = (ly[cl] == 0) ? 1 : div_lat + 1;
                    exp_z   = (ly[cl] == 0) ? 63 : lx[cl] / ly[cl];
                    exp_err = (ly[cl] == 0) ? 1 : 0;
                end
            end else if (active) begin
                cyc++;
                if (cyc == exp_cyc) begin
                    check_output("rnd_rsp_valid", bus.rsp_valid, 1 << cl);
                    check_output("rnd_rsp_z", bus.rsp_z, exp_z);
                    check_output("rnd_rsp_err", bus.rsp_err, exp_err);
                    active    = 1'b0;
                    resp_now  = 1'b1;
                    post_resp = 1'b1;
                    model_ptr = (cl + 1) % N;
                    n_ops++;
                end else begin
                    check_output("rnd_quiet", bus.rsp_valid, 0);
                end
            end else if (post_resp) begin
                check_output("rnd_idle_gnt", bus.gnt, 0);
                check_output("rnd_idle_rsp", bus.rsp_valid, 0);
                post_resp = 1'b0;
                idle      = 1'b1;
            end
            if (resp_now) div_lat = $urandom_range(1, 12);
            for (int i = 0; i < N; i++) begin
                if (resp_now && i == cl) begin
                    lane_req[i] = 1'b0;
                end else if (!lane_req[i] && $urandom_range(0, 2) == 0) begin
                    lane_req[i] = 1'b1;
                    lx[i] = $urandom_range(0, 63);
                    ly[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
                end
            end
            bus.req = lane_req;
            for (int i = 0; i < N; i++) begin
                bus.x_in[i*W +: W] = (active && i == cl) ? 6'($urandom) : 6'(lx[i]);
                bus.y_in[i*W +: W] = (active && i == cl) ? 6'($urandom) : 6'(ly[i]);
            end
            if (idle) begin
                cand_lane = pick(lane_req, model_ptr);
                exp_gnt   = (cand_lane < 0) ? '0 : (N'(1) << cand_lane);
                if (cand_lane >= 0) cl = cand_lane;
                pending = 1'b1;
                idle    = 1'b0;
            end
        end
        check_output("rnd_ops_done", (n_ops > 50), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
